// File: rtl/multi_tone_dds.sv
// -----------------------------------------------------------------------------
// multi_tone_dds
//
// N-channel direct-digital-synthesis tone generator. A programmable tick counter
// sets the sample rate as a clock enable on clk_in. On every tick, each channel's
// phase accumulator advances by its tuning word. The phase top bits address a
// shared sine ROM. The ROM sample is scaled by a per-channel 8-bit amplitude.
// All channels are then summed into a full-precision composite.
//
// Pipeline (tick seen in cycle T, sample_valid high in cycle T+4):
//   stage 1 : phase accumulate, amplitude captured with the tick
//   stage 2 : registered sine ROM read
//   stage 3 : amplitude scaling (floor rounding)
//   stage 4 : output registers and composite sum, sample_valid pulse
//
// Ports:
//   clk_in       in   system clock
//   reset_p      in   asynchronous active-high reset (clears all state)
//   enable       in   1 = tick counter runs, 0 = counter frozen and no ticks
//   sample_div   in   tick period minus one
//   ftw          in   per-channel tuning words, channel i at [i*PHASE_W +: PHASE_W]
//   amp          in   per-channel unsigned amplitude, channel i at [i*8 +: 8]
//   cfg_load     in   strobe: capture ftw/amp into the active configuration
//   phase_clr    in   synchronous clear of all phase accumulators
//   sin_out      out  per-channel signed samples, channel i at [i*DATA_W +: DATA_W]
//   mix_out      out  signed sum of all channel samples
//   sample_valid out  one-cycle pulse when sin_out/mix_out update
// -----------------------------------------------------------------------------
module multi_tone_dds #(
    parameter  int NCH     = 2,
    parameter  int PHASE_W = 24,
    parameter  int LUT_AW  = 5,
    parameter  int DATA_W  = 8,
    localparam int MIX_W   = DATA_W + $clog2(NCH)
) (
    input  logic                      clk_in,
    input  logic                      reset_p,
    input  logic                      enable,
    input  logic [15:0]               sample_div,
    input  logic [NCH*PHASE_W-1:0]    ftw,
    input  logic [NCH*8-1:0]          amp,
    input  logic                      cfg_load,
    input  logic                      phase_clr,
    output logic [NCH*DATA_W-1:0]     sin_out,
    output logic signed [MIX_W-1:0]   mix_out,
    output logic                      sample_valid
);

    localparam int  LUT_SZ = 2 ** LUT_AW;
    localparam int  PROD_W = DATA_W + 9;
    localparam real PI     = 3.14159265358979323846;

    // Sine ROM entry, rounded half away from zero to the peak of the signed
    // sample range.
    function automatic logic signed [DATA_W-1:0] sine_entry(input int k);
        real peak;
        real x;
        int  r;
        peak = real'((2 ** (DATA_W - 1)) - 1);
        x    = peak * $sin(2.0 * PI * real'(k) / real'(LUT_SZ));
        if (x >= 0.0) r = $rtoi(x + 0.5);
        else          r = -$rtoi(0.5 - x);
        return r[DATA_W-1:0];
    endfunction

    // (sample * gain) >>> 8, floor rounding; |sample| <= 2^(DATA_W-1)-1 and
    // gain < 256, so the result always fits DATA_W bits.
    function automatic logic signed [DATA_W-1:0] scale_amp(
        input logic signed [DATA_W-1:0] smp,
        input logic [7:0]               gain
    );
        logic signed [PROD_W-1:0] prod;
        prod = PROD_W'(smp) * PROD_W'($signed({1'b0, gain}));
        prod = prod >>> 8;
        return prod[DATA_W-1:0];
    endfunction

    logic signed [DATA_W-1:0] lut_rom [LUT_SZ];

    for (genvar k = 0; k < LUT_SZ; k++) begin : g_rom
        assign lut_rom[k] = sine_entry(k);
    end

    // State and pipeline registers
    logic [15:0]              cnt_q,        cnt_d;
    logic [NCH*PHASE_W-1:0]   act_ftw_q,    act_ftw_d;
    logic [NCH*8-1:0]         act_amp_q,    act_amp_d;
    logic [PHASE_W-1:0]       phase_q       [NCH];
    logic [PHASE_W-1:0]       phase_d       [NCH];
    logic [7:0]               amp_p1_q      [NCH];
    logic [7:0]               amp_p1_d      [NCH];
    logic                     vld_p1_q,     vld_p1_d;
    logic signed [DATA_W-1:0] lut_p2_q      [NCH];
    logic signed [DATA_W-1:0] lut_p2_d      [NCH];
    logic [7:0]               amp_p2_q      [NCH];
    logic [7:0]               amp_p2_d      [NCH];
    logic                     vld_p2_q,     vld_p2_d;
    logic signed [DATA_W-1:0] scl_p3_q      [NCH];
    logic signed [DATA_W-1:0] scl_p3_d      [NCH];
    logic                     vld_p3_q,     vld_p3_d;
    logic [NCH*DATA_W-1:0]    sin_out_q,    sin_out_d;
    logic signed [MIX_W-1:0]  mix_out_q,    mix_out_d;
    logic                     sample_valid_q, sample_valid_d;

    logic                     tick;
    logic signed [MIX_W-1:0]  mix_sum;

    always_comb begin
        // Tick counter: >= compare so a lowered sample_div wraps immediately.
        tick  = enable && (cnt_q >= sample_div);
        cnt_d = cnt_q;
        if (enable) cnt_d = tick ? 16'd0 : cnt_q + 16'd1;

        // A load coincident with a tick is already used by that tick.
        act_ftw_d = cfg_load ? ftw : act_ftw_q;
        act_amp_d = cfg_load ? amp : act_amp_q;

        // ---- stage 1: phase accumulate ----
        for (int i = 0; i < NCH; i++) begin
            phase_d[i]  = phase_q[i];
            amp_p1_d[i] = amp_p1_q[i];
            if (phase_clr)
                phase_d[i] = '0;
            else if (tick)
                phase_d[i] = phase_q[i] + act_ftw_d[i*PHASE_W +: PHASE_W];
            if (tick)
                amp_p1_d[i] = act_amp_d[i*8 +: 8];
        end
        vld_p1_d = tick;

        // ---- stage 2: sine ROM read ----
        for (int i = 0; i < NCH; i++) begin
            lut_p2_d[i] = lut_rom[phase_q[i][PHASE_W-1 -: LUT_AW]];
            amp_p2_d[i] = amp_p1_q[i];
        end
        vld_p2_d = vld_p1_q;

        // ---- stage 3: amplitude scaling ----
        for (int i = 0; i < NCH; i++) begin
            scl_p3_d[i] = scale_amp(lut_p2_q[i], amp_p2_q[i]);
        end
        vld_p3_d = vld_p2_q;

        // ---- stage 4: outputs and composite ----
        mix_sum = '0;
        for (int i = 0; i < NCH; i++) begin
            mix_sum = mix_sum + MIX_W'(scl_p3_q[i]);
        end
        sin_out_d = sin_out_q;
        mix_out_d = mix_out_q;
        if (vld_p3_q) begin
            for (int i = 0; i < NCH; i++) begin
                sin_out_d[i*DATA_W +: DATA_W] = scl_p3_q[i];
            end
            mix_out_d = mix_sum;
        end
        sample_valid_d = vld_p3_q;
    end

    always_ff @(posedge clk_in or posedge reset_p) begin
        if (reset_p) begin
            cnt_q          <= '0;
            act_ftw_q      <= '0;
            act_amp_q      <= '0;
            vld_p1_q       <= 1'b0;
            vld_p2_q       <= 1'b0;
            vld_p3_q       <= 1'b0;
            sin_out_q      <= '0;
            mix_out_q      <= '0;
            sample_valid_q <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                phase_q[i]  <= '0;
                amp_p1_q[i] <= '0;
                lut_p2_q[i] <= '0;
                amp_p2_q[i] <= '0;
                scl_p3_q[i] <= '0;
            end
        end else begin
            cnt_q          <= cnt_d;
            act_ftw_q      <= act_ftw_d;
            act_amp_q      <= act_amp_d;
            vld_p1_q       <= vld_p1_d;
            vld_p2_q       <= vld_p2_d;
            vld_p3_q       <= vld_p3_d;
            sin_out_q      <= sin_out_d;
            mix_out_q      <= mix_out_d;
            sample_valid_q <= sample_valid_d;
            for (int i = 0; i < NCH; i++) begin
                phase_q[i]  <= phase_d[i];
                amp_p1_q[i] <= amp_p1_d[i];
                lut_p2_q[i] <= lut_p2_d[i];
                amp_p2_q[i] <= amp_p2_d[i];
                scl_p3_q[i] <= scl_p3_d[i];
            end
        end
    end

    assign sin_out      = sin_out_q;
    assign mix_out      = mix_out_q;
    assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_multi_tone_dds.sv
// -----------------------------------------------------------------------------
// tb_multi_tone_dds
//
// Bench for multi_tone_dds with NCH=2, PHASE_W=24, LUT_AW=5, DATA_W=8.
// The stimulus process queues the expected sample and its arrival cycle for
// every tick it issues. The monitor pops one entry per sample_valid pulse.
// Expected values come from hand-computed tables of (LUT[k]*amp)>>>8.
// -----------------------------------------------------------------------------
module tb_multi_tone_dds;

    logic        clk_in = 1'b0;
    logic        reset_p;
    logic        enable;
    logic [15:0] sample_div;
    logic [47:0] ftw;
    logic [15:0] amp;
    logic        cfg_load;
    logic        phase_clr;
    logic [15:0] sin_out;
    logic signed [8:0] mix_out;
    logic        sample_valid;

    multi_tone_dds #(
        .NCH(2), .PHASE_W(24), .LUT_AW(5), .DATA_W(8)
    ) dut (
        .clk_in       (clk_in),
        .reset_p      (reset_p),
        .enable       (enable),
        .sample_div   (sample_div),
        .ftw          (ftw),
        .amp          (amp),
        .cfg_load     (cfg_load),
        .phase_clr    (phase_clr),
        .sin_out      (sin_out),
        .mix_out      (mix_out),
        .sample_valid (sample_valid)
    );

    always #5 clk_in = ~clk_in;

    // (LUT[k]*255)>>>8 and (LUT[k]*128)>>>8, LUT = round(127*sin(2*pi*k/32))
    int s255 [32] = '{0, 24, 48, 70, 89, 105, 116, 124, 126, 124, 116, 105, 89, 70, 48, 24,
                      0, -25, -49, -71, -90, -106, -117, -125, -127, -125, -117, -106, -90, -71, -49, -25};
    int s128 [32] = '{0, 12, 24, 35, 45, 53, 58, 62, 63, 62, 58, 53, 45, 35, 24, 12,
                      0, -13, -25, -36, -45, -53, -59, -63, -64, -63, -59, -53, -45, -36, -25, -13};

    typedef struct {
        int cyc;
        int c0;
        int c1;
        int mx;
    } sb_t;

    sb_t sbq[$];
    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;

    initial forever begin
        @(posedge clk_in);
        cyc++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int mod32(input int x);
        return ((x % 32) + 32) % 32;
    endfunction

    function automatic int expv(input int idx, input int a);
        if (a == 255) return s255[idx];
        if (a == 128) return s128[idx];
        return 0;
    endfunction

    // Monitor: one scoreboard entry per sample_valid pulse.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk_in);
            if (!reset_p && sample_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got valid with empty queue (cycle %0d)", cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("valid_cycle", cyc, e.cyc);
                    chk("ch0", int'($signed(sin_out[7:0])), e.c0);
                    chk("ch1", int'($signed(sin_out[15:8])), e.c1);
                    chk("mix", int'(mix_out), e.mx);
                end
            end
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 300) begin
            @(posedge clk_in);
            n++;
        end
        #1;
        chk("drain_pending", sbq.size(), 0);
        sbq.delete();
    endtask

    task automatic set_cfg(input logic [23:0] f0, input logic [23:0] f1,
                           input logic [7:0] a0, input logic [7:0] a1);
        ftw = {f1, f0};
        amp = {a1, a0};
    endtask

    task automatic pulse_cfg();
        cfg_load = 1'b1;
        @(posedge clk_in);
        #1;
        cfg_load = 1'b0;
    endtask

    task automatic pulse_clr();
        phase_clr = 1'b1;
        @(posedge clk_in);
        #1;
        phase_clr = 1'b0;
    endtask

    // Run exactly k ticks at period div+1 (counter starts and ends at 0).
    // Channel c index for sample m is b_c + s_c*(m+1), amplitude a_c.
    task automatic run_ticks(input int div, input int k,
                             input int b0, input int s0, input int a0,
                             input int b1, input int s1, input int a1);
        int  p;
        sb_t e;
        p = cyc;
        for (int m = 0; m < k; m++) begin
            e.cyc = p + div + 4 + (div + 1) * m;
            e.c0  = expv(mod32(b0 + s0 * (m + 1)), a0);
            e.c1  = expv(mod32(b1 + s1 * (m + 1)), a1);
            e.mx  = e.c0 + e.c1;
            sbq.push_back(e);
        end
        sample_div = 16'(div);
        enable     = 1'b1;
        repeat ((div + 1) * k) @(posedge clk_in);
        #1;
        enable = 1'b0;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  p;
        sb_t e;

        // 1. Reset with inputs toggling
        reset_p    = 1'b1;
        enable     = 1'b0;
        sample_div = '0;
        ftw        = '0;
        amp        = '0;
        cfg_load   = 1'b0;
        phase_clr  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_in);
            #1;
            ftw        = 48'({$urandom(), $urandom()});
            amp        = 16'($urandom());
            sample_div = 16'($urandom());
            enable     = 1'($urandom());
            cfg_load   = 1'($urandom());
            phase_clr  = 1'($urandom());
            @(negedge clk_in);
            chk("rst_valid", int'(sample_valid), 0);
            chk("rst_sin", int'(sin_out), 0);
            chk("rst_mix", int'(mix_out), 0);
        end
        @(posedge clk_in);
        #1;
        enable     = 1'b0;
        cfg_load   = 1'b0;
        phase_clr  = 1'b0;
        sample_div = '0;
        reset_p    = 1'b0;
        @(posedge clk_in);
        #1;
        // Never-loaded config: all samples zero regardless of ftw/amp ports.
        run_ticks(0, 4, 0, 0, 0, 0, 0, 0);

        // 2. Single tone, one LUT step per sample, full period
        set_cfg(24'h080000, 24'h000000, 8'd255, 8'd0);
        pulse_cfg();
        run_ticks(4, 32, 0, 1, 255, 0, 0, 0);

        // 3. Two identical tones mixed
        set_cfg(24'h080000, 24'h080000, 8'd255, 8'd255);
        pulse_cfg();
        pulse_clr();
        run_ticks(1, 32, 0, 1, 255, 0, 1, 255);

        // 4. Config staging: port change alone has no effect
        set_cfg(24'h100000, 24'h080000, 8'd255, 8'd255);
        run_ticks(2, 4, 0, 1, 255, 0, 1, 255);
        pulse_cfg();
        run_ticks(2, 4, 4, 2, 255, 4, 1, 255);

        // 5. Negative step through wrap; sample 32 returns to index 0
        set_cfg(24'hF80000, 24'h000000, 8'd255, 8'd0);
        pulse_cfg();
        pulse_clr();
        run_ticks(0, 33, 0, -1, 255, 0, 0, 0);

        // Floor rounding at half amplitude: idx 8,16,24,0 -> 63,0,-64,0
        set_cfg(24'h400000, 24'h000000, 8'd128, 8'd0);
        pulse_cfg();
        pulse_clr();
        run_ticks(3, 4, 0, 8, 128, 0, 0, 0);

        // 6a. phase_clr coincident with a tick
        set_cfg(24'h080000, 24'h000000, 8'd255, 8'd0);
        pulse_cfg();
        run_ticks(0, 3, 0, 1, 255, 0, 0, 0);
        p     = cyc;
        e.cyc = p + 4;
        e.c0  = 0;
        e.c1  = 0;
        e.mx  = 0;
        sbq.push_back(e);
        sample_div = '0;
        enable     = 1'b1;
        phase_clr  = 1'b1;
        @(posedge clk_in);
        #1;
        enable    = 1'b0;
        phase_clr = 1'b0;
        drain();
        run_ticks(0, 2, 0, 1, 255, 0, 0, 0);

        // 6b. Reset two cycles after a tick: the in-flight sample is lost
        chk("pre_rst_ch0", int'($signed(sin_out[7:0])), 48);
        sample_div = '0;
        enable     = 1'b1;
        @(posedge clk_in);
        #1;
        enable = 1'b0;
        @(posedge clk_in);
        #1;
        reset_p = 1'b1;
        #1;
        chk("midrst_valid", int'(sample_valid), 0);
        chk("midrst_ch0", int'($signed(sin_out[7:0])), 0);
        @(posedge clk_in);
        #1;
        reset_p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_in);
            chk("post_rst_valid", int'(sample_valid), 0);
        end
        chk("post_rst_sin", int'(sin_out), 0);
        chk("post_rst_mix", int'(mix_out), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
